// File: rtl/rvfi_trace_packer.sv
// Captures RVFI retirements into a packet FIFO and drains each packet as a
// 32-bit valid/ready word stream (4 words, or 5 when the retire touched memory).
module rvfi_trace_packer #(
  parameter int unsigned DEPTH = 4,
  parameter logic [7:0]  SYNC  = 8'hA5
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     trace_en_i,
  input  logic                     rvfi_valid,
  input  logic [63:0]              rvfi_order,
  input  logic [31:0]              rvfi_insn,
  input  logic                     rvfi_trap,
  input  logic                     rvfi_intr,
  input  logic [4:0]               rvfi_rd_addr,
  input  logic [31:0]              rvfi_rd_wdata,
  input  logic [31:0]              rvfi_pc_rdata,
  input  logic [31:0]              rvfi_mem_addr,
  input  logic [3:0]               rvfi_mem_rmask,
  input  logic [3:0]               rvfi_mem_wmask,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [31:0]              trace_data_o,
  output logic                     trace_last_o,
  output logic [$clog2(DEPTH):0]   fifo_level_o,
  output logic [15:0]              drop_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef struct packed {
    logic [7:0]  order;
    logic        trap;
    logic        intr;
    logic [4:0]  rd_addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic        gap;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
  } pkt_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Handshake: a word transfers on any rising clk_i where trace_valid_o and
  // trace_ready_i are both high; valid, data and last hold until that happens.

  state_e          state_q, state_d;
  pkt_t            mem_q [DEPTH];
  pkt_t            mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [2:0]      widx_q, widx_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic            drop_pending_q, drop_pending_d;

  logic            push;
  logic            drop;
  logic            pop;
  logic            hs;
  logic            is_last;
  logic            has_mem;
  logic [2:0]      last_idx;
  logic [31:0]     word;
  pkt_t            head;
  pkt_t            pkt_in;
  logic            unused_order;

  assign unused_order = ^rvfi_order[63:8];

  // Full/empty decisions use only the registered level, so a same-cycle pop
  // never makes room for an incoming retire.
  assign push = rvfi_valid && trace_en_i && (level_q <  LW'(DEPTH));
  assign drop = rvfi_valid && trace_en_i && (level_q == LW'(DEPTH));

  always_comb begin
    pkt_in          = '0;
    pkt_in.order    = rvfi_order[7:0];
    pkt_in.trap     = rvfi_trap;
    pkt_in.intr     = rvfi_intr;
    pkt_in.rd_addr  = rvfi_rd_addr;
    pkt_in.rmask    = rvfi_mem_rmask;
    pkt_in.wmask    = rvfi_mem_wmask;
    pkt_in.gap      = drop_pending_q;
    pkt_in.pc       = rvfi_pc_rdata;
    pkt_in.insn     = rvfi_insn;
    pkt_in.rd_wdata = rvfi_rd_wdata;
    pkt_in.mem_addr = rvfi_mem_addr;
  end

  assign head     = mem_q[rd_ptr_q];
  assign has_mem  = |(head.rmask | head.wmask);
  assign last_idx = has_mem ? 3'd4 : 3'd3;
  assign is_last  = (widx_q == last_idx);

  always_comb begin
    word = '0;
    case (widx_q)
      3'd0:    word = {SYNC, head.trap, head.intr, head.rd_addr, head.rmask,
                       head.wmask, head.gap, head.order};
      3'd1:    word = head.pc;
      3'd2:    word = head.insn;
      3'd3:    word = head.rd_wdata;
      default: word = head.mem_addr;
    endcase
  end

  assign trace_valid_o = (state_q == ST_SEND);
  assign hs            = trace_valid_o && trace_ready_i;
  assign pop           = hs && is_last;
  // Gated so the idle bus reads zero rather than a stale head header.
  assign trace_data_o  = trace_valid_o ? word : 32'h0;
  assign trace_last_o  = trace_valid_o && is_last;
  assign fifo_level_o  = level_q;
  assign drop_cnt_o    = drop_cnt_q;

  always_comb begin
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    level_d        = level_q;
    widx_d         = widx_q;
    drop_cnt_d     = drop_cnt_q;
    drop_pending_d = drop_pending_q;

    if (push) begin
      mem_d[wr_ptr_q] = pkt_in;
      wr_ptr_d        = wr_ptr_q + 1'b1;
      drop_pending_d  = 1'b0;
    end
    if (drop) begin
      drop_pending_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
    if (hs) widx_d = is_last ? 3'd0 : widx_q + 3'd1;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (push) state_d = ST_SEND;
      ST_SEND: if (pop && !push && (level_q == LW'(1))) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      widx_q         <= '0;
      drop_cnt_q     <= '0;
      drop_pending_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      widx_q         <= widx_d;
      drop_cnt_q     <= drop_cnt_d;
      drop_pending_q <= drop_pending_d;
      mem_q          <= mem_d;
    end
  end

endmodule

// File: doc/rvfi_trace_packer.md
# rvfi_trace_packer

Downstream consumer of the core's RVFI retirement port, instantiated beside `ibex_tracer` in `ibex_top_tracing`. Each retired instruction is captured into a packet FIFO, and the FIFO is drained as a 32-bit valid/ready word stream for an off-core trace sink (UART or DMA). Memory accesses produce one extra word. Packets that arrive while the FIFO is full are dropped and counted; the next accepted packet is flagged.

## Interface
- `DEPTH`, default 4: packet FIFO entries; power of two, minimum 2.
- `SYNC`, default 8'hA5: header sync byte.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. One clock; reset is asynchronous and active-low.
- `trace_en_i` in 1: capture enable. While low, `rvfi_valid` is ignored and is not counted as a drop.
- `rvfi_valid` in 1: retirement strobe.
- `rvfi_order` in 64: retirement index. Only bits [7:0] are used.
- `rvfi_insn` in 32: instruction word.
- `rvfi_trap` in 1: trap flag.
- `rvfi_intr` in 1: interrupt flag.
- `rvfi_rd_addr` in 5: destination register.
- `rvfi_rd_wdata` in 32: destination register write data.
- `rvfi_pc_rdata` in 32: PC of the retired instruction.
- `rvfi_mem_addr` in 32: memory address.
- `rvfi_mem_rmask` in 4: memory read byte mask.
- `rvfi_mem_wmask` in 4: memory write byte mask.
- `trace_valid_o` out 1: output word valid.
- `trace_ready_i` in 1: sink ready.
- `trace_data_o` out 32: output word.
- `trace_last_o` out 1: high on the final word of a packet.
- `fifo_level_o` out $clog2(DEPTH)+1: number of stored packets.
- `drop_cnt_o` out 16: count of dropped packets; saturates at 16'hFFFF.

## Operation
- **Capture.** A push occurs when `rvfi_valid && trace_en_i && level < DEPTH`, where `level` is the registered value. The push stores all fields plus `gap = drop_pending`, then clears `drop_pending`.
- **Drop.** A drop occurs when `rvfi_valid && trace_en_i && level == DEPTH`. The drop sets `drop_pending` and increments `drop_cnt_o` (saturating). A pop in the same cycle does not rescue the packet: the full check uses the registered level.
- **Packet format** (word order):
  - W0 header: [31:24]=SYNC, [23]=trap, [22]=intr, [21:17]=rd_addr, [16:13]=rmask, [12:9]=wmask, [8]=gap, [7:0]=order[7:0].
  - W1: pc_rdata.
  - W2: insn.
  - W3: rd_wdata.
  - W4: mem_addr. Present only if `(rmask | wmask) != 0`.
- `trace_last_o` is asserted on W3 for a 4-word packet and on W4 for a 5-word packet.
- **Drain state machine.** A word index `widx` (0..4) selects the word of the FIFO head entry.
  - States: IDLE (empty) and SEND.
  - In SEND, a handshake (`trace_valid_o && trace_ready_i`) advances `widx`.
  - A handshake on the last word resets `widx` to 0 and pops the head. The machine returns to IDLE if the FIFO is then empty with no push that cycle.
- **Simultaneous push and pop** in one cycle leaves `level` unchanged. Pointers wrap modulo DEPTH.
- `trace_en_i` deassertion does not flush the FIFO; stored packets still drain.

## Timing
- **Reset values:**
  - `trace_valid_o`=0, `trace_data_o`=0, `trace_last_o`=0.
  - `fifo_level_o`=0, `drop_cnt_o`=0.
  - `drop_pending`=0, `widx`=0, pointers=0, storage=0.
- **Reset mid-packet** discards all contents. After reset release, no partial word is emitted.
- **Latency.** A packet pushed at edge N gives `trace_valid_o`=1 with W0 from cycle N+1. There is no combinational path from `rvfi_*` to the outputs.
- **Output protocol:**
  - `trace_data_o` and `trace_last_o` are combinational from the head entry and `widx`.
  - Once `trace_valid_o` rises, data, last and valid hold stable until a handshake.
  - `trace_valid_o` never drops without a handshake.
- **Throughput.** With `trace_ready_i` held at 1, the block emits one word per cycle with no bubble between packets.
- `fifo_level_o` updates at the edge after a push or pop.

## Test plan
- **Single ALU retire.** Stimulus: pc=0x00100080, insn=0x00500093, rd=1, wdata=5, masks=0, order=0, ready=1. Required: 4 words, W0=0xA5020000, W1=0x00100080, W2=0x00500093, W3=0x00000005, `last` on W3.
- **Store retire.** Stimulus: wmask=4'hF, mem_addr=0x00002000. Required: 5 words, W0[12:9]=4'hF, W4=0x00002000, `last` only on W4.
- **Backpressure.** Stimulus: ready=0 for 10 cycles after valid, then 1. Required: W0 held stable throughout; `fifo_level_o`=1; no words lost or duplicated.
- **Overflow.** Stimulus: ready=0, DEPTH+3 consecutive retires. Required: `fifo_level_o`=4, `drop_cnt_o`=3. A retire pushed after draining has header bit 8=1; the packet after it has bit 8=0.
- **Push and pop at full.** Stimulus: retire in the same cycle as the last-word handshake with level=DEPTH. Required: the packet is dropped (`drop_cnt_o`+1); `fifo_level_o` goes to DEPTH-1.
- **Reset and enable.** Stimulus: `rst_ni` low during W2 of a packet; then `trace_en_i`=0 with 3 retires. Required: all outputs at reset values; level stays 0; `drop_cnt_o` stays 0.
